// File: rtl/seq_det_n.sv
// seq_det_n: scans a latched WIDTH-bit word one bit per clock (bit 0 first)
// and flags every position where the last PLEN bits equal PATTERN.
// PATTERN[PLEN-1] is the oldest (first) bit of the match window.
//
// Ports
//   CLK    in   system clock, rising edge
//   RST    in   asynchronous active-low reset
//   START  in   launch pulse, honoured only in IDLE
//   K0     in   0 = overlapping, 1 = non-overlapping detection (latched)
//   Ks     in   word to scan (latched at launch)
//   BUSY   out  high in SCAN and FIN
//   DONE   out  one-cycle pulse in FIN
//   FLAGS  out  FLAGS[i] set when a match ends at bit i
//   CNT    out  number of matches
//   NUM    out  seven-segment {a,b,c,d,e,f,g,dp} decode of CNT, dp = 0
//
// Build option: define SEG_HEX_EN to extend the NUM decode to 10..15 (A-F);
// without it only 0..9 decode and larger counts blank the display.
//
// state | meaning
// IDLE  | waiting for START, FLAGS/CNT hold the last result
// SCAN  | processing one bit of the latched word per clock
// FIN   | scan complete, DONE high for this one cycle

module seq_det_n #(
  parameter int WIDTH = 8,
  parameter int PLEN = 3,
  parameter logic [PLEN-1:0] PATTERN = 3'b101
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           START,
  input  logic                           K0,
  input  logic [WIDTH-1:0]               Ks,
  output logic                           BUSY,
  output logic                           DONE,
  output logic [WIDTH-1:0]               FLAGS,
  output logic [$clog2(WIDTH+1)-1:0]     CNT,
  output logic [7:0]                     NUM
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);
  localparam int VW = $clog2(PLEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  ks_q;
  logic              k0_q;
  logic [IW-1:0]     idx;
  logic [PLEN-1:0]   hist;
  logic [VW-1:0]     vcnt;

  logic [PLEN-1:0]   hist_nxt;
  logic [VW-1:0]     vcnt_nxt;
  logic              match;

  // Next history / valid-count for the bit under the index; a match needs
  // a full window of valid bits, which is what makes non-overlap work.
  always_comb begin
    hist_nxt = {hist[PLEN-2:0], ks_q[idx]};
    vcnt_nxt = (vcnt == VW'(PLEN)) ? vcnt : vcnt + VW'(1);
    match    = (hist_nxt == PATTERN) && (vcnt_nxt == VW'(PLEN));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      ks_q  <= '0;
      k0_q  <= 1'b0;
      idx   <= '0;
      hist  <= '0;
      vcnt  <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      FLAGS <= '0;
      CNT   <= '0;
    end else begin
      case (state)
        IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            ks_q  <= Ks;
            k0_q  <= K0;
            idx   <= '0;
            hist  <= '0;
            vcnt  <= '0;
            FLAGS <= '0;
            CNT   <= '0;
            BUSY  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          hist <= hist_nxt;
          vcnt <= (match && k0_q) ? '0 : vcnt_nxt;
          if (match) begin
            FLAGS[idx] <= 1'b1;
            CNT        <= CNT + CW'(1);
          end
          if (idx == IW'(WIDTH - 1)) begin
            DONE  <= 1'b1;
            state <= FIN;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        FIN: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  logic [6:0] seg;

  always_comb begin
    seg = 7'b0000000;
    case (32'(CNT))
      32'd0:  seg = 7'b1111110;
      32'd1:  seg = 7'b0110000;
      32'd2:  seg = 7'b1101101;
      32'd3:  seg = 7'b1111001;
      32'd4:  seg = 7'b0110011;
      32'd5:  seg = 7'b1011011;
      32'd6:  seg = 7'b1011111;
      32'd7:  seg = 7'b1110000;
      32'd8:  seg = 7'b1111111;
      32'd9:  seg = 7'b1111011;
`ifdef SEG_HEX_EN
      32'd10: seg = 7'b1110111;
      32'd11: seg = 7'b0011111;
      32'd12: seg = 7'b1001110;
      32'd13: seg = 7'b0111101;
      32'd14: seg = 7'b1001111;
      32'd15: seg = 7'b1000111;
`else
`endif
      default: seg = 7'b0000000;
    endcase
    NUM = {seg, 1'b0};
  end

endmodule

// File: tb/tb_seq_det_n.sv
module tb_seq_det_n;

  localparam int W  = 8;
  localparam int W2 = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic        K0 = 1'b0;
  logic [7:0]  Ks = '0;
  logic        BUSY, DONE;
  logic [7:0]  FLAGS;
  logic [3:0]  CNT;
  logic [7:0]  NUM;

  logic        START2 = 1'b0;
  logic        K0_2 = 1'b0;
  logic [15:0] Ks2 = '0;
  logic        BUSY2, DONE2;
  logic [15:0] FLAGS2;
  logic [4:0]  CNT2;
  logic [7:0]  NUM2;

  seq_det_n dut (
    .CLK(CLK), .RST(RST), .START(START), .K0(K0), .Ks(Ks),
    .BUSY(BUSY), .DONE(DONE), .FLAGS(FLAGS), .CNT(CNT), .NUM(NUM)
  );

  seq_det_n #(.WIDTH(16), .PLEN(2), .PATTERN(2'b11)) dut2 (
    .CLK(CLK), .RST(RST), .START(START2), .K0(K0_2), .Ks(Ks2),
    .BUSY(BUSY2), .DONE(DONE2), .FLAGS(FLAGS2), .CNT(CNT2), .NUM(NUM2)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: slide a PLEN window over the word; in non-overlap mode a
  // window may not reuse any bit of the previous match.
  function automatic void model(input logic [31:0] ks, input int w, input int plen,
                                input logic [31:0] pat, input logic k0,
                                output logic [31:0] flags, output int cnt);
    int last_end = -1;
    flags = '0;
    cnt = 0;
    for (int i = plen - 1; i < w; i++) begin
      bit hit = 1'b1;
      if (k0 && (i - plen + 1) <= last_end) hit = 1'b0;
      for (int j = 0; j < plen; j++)
        if (ks[i-j] != pat[j]) hit = 1'b0;
      if (hit) begin
        flags[i] = 1'b1;
        cnt++;
        last_end = i;
      end
    end
  endfunction

  function automatic logic [7:0] seg_ref(input int c);
    logic [6:0] s;
    case (c)
      0: s = 7'b1111110;  1: s = 7'b0110000;  2: s = 7'b1101101;
      3: s = 7'b1111001;  4: s = 7'b0110011;  5: s = 7'b1011011;
      6: s = 7'b1011111;  7: s = 7'b1110000;  8: s = 7'b1111111;
      9: s = 7'b1111011;
`ifdef SEG_HEX_EN
      10: s = 7'b1110111; 11: s = 7'b0011111; 12: s = 7'b1001110;
      13: s = 7'b0111101; 14: s = 7'b1001111; 15: s = 7'b1000111;
`endif
      default: s = 7'b0000000;
    endcase
    return {s, 1'b0};
  endfunction

  typedef struct {
    logic [7:0] flags;
    int         cnt;
    logic [7:0] num;
    int         done_cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] last_flags = '0;
  int         last_cnt = 0;

  // Monitor: pops on every DONE, tracks DONE width and BUSY run length.
  logic done_prev = 1'b0;
  int   busy_run = 0;
  int   last_busy_run = 0;
  always @(negedge CLK) begin
    if (DONE) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("flags", FLAGS, e.flags);
        check("cnt", CNT, e.cnt);
        check("num", NUM, e.num);
        check("done_cycle", cyc, e.done_cyc);
      end
      if (done_prev) check("done_width", 2, 1);
    end
    done_prev = DONE;
    if (BUSY) busy_run++;
    else if (busy_run > 0) begin
      last_busy_run = busy_run;
      busy_run = 0;
    end
  end

  // Called at a negedge; returns just after the edge that samples START,
  // then scrambles the inputs to show only the latched copies matter.
  task automatic launch(input logic [7:0] ks, input logic k0, input bit push_model,
                        input bit push_fixed, input logic [7:0] fx_flags, input int fx_cnt);
    exp_t e;
    Ks = ks;
    K0 = k0;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    Ks = 8'($urandom);
    K0 = 1'($urandom);
    e.done_cyc = cyc + W;
    if (push_model) begin
      logic [31:0] f;
      int c;
      model({24'b0, ks}, W, 3, 32'b101, k0, f, c);
      e.flags = f[7:0];
      e.cnt = c;
    end else begin
      e.flags = fx_flags;
      e.cnt = fx_cnt;
    end
    e.num = seg_ref(e.cnt);
    if (push_model || push_fixed) begin
      sb.push_back(e);
      last_flags = e.flags;
      last_cnt = e.cnt;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge CLK);
    while (BUSY && n < 64) begin
      n++;
      @(negedge CLK);
    end
    if (n >= 64) check("idle_timeout", n, 0);
    @(negedge CLK);
    check("busy_len", last_busy_run, W + 1);
  endtask

  task automatic check_hold();
    @(negedge CLK);
    @(negedge CLK);
    check("hold_flags", FLAGS, last_flags);
    check("hold_cnt", CNT, last_cnt);
    check("hold_busy", BUSY, 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_done"}, DONE, 0);
    check({tag, "_flags"}, FLAGS, 0);
    check({tag, "_cnt"}, CNT, 0);
    check({tag, "_num"}, NUM, 8'b11111100);
  endtask

  initial begin
    #1;
    check_reset_state("rst0");
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    // overlapping case, START on the first edge after reset release
    launch(8'b10101101, 1'b0, 0, 1, 8'b10100100, 3);
    wait_idle();
    check_hold();

    @(negedge CLK);
    launch(8'b10101101, 1'b1, 0, 1, 8'b00100100, 2);
    wait_idle();
    check_hold();

    // all-zero word, with a START inside the scan that must be ignored
    @(negedge CLK);
    launch(8'h00, 1'b0, 0, 1, 8'h00, 0);
    @(negedge CLK);
    @(negedge CLK);
    Ks = 8'b10101101;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_idle();
    check_hold();

    // reset mid-scan: immediate clear, no DONE afterwards
    @(negedge CLK);
    launch(8'b10101101, 1'b0, 0, 0, 8'h00, 0);
    repeat (3) @(negedge CLK);
    #2 RST = 1'b0;
    #1 check_reset_state("rst_mid");
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    repeat (12) @(negedge CLK);
    check("abort_busy", BUSY, 0);
    launch(8'b10101101, 1'b0, 0, 1, 8'b10100100, 3);
    wait_idle();

    // randomized scans against the reference model
    for (int t = 0; t < 40; t++) begin
      @(negedge CLK);
      launch(8'($urandom), 1'($urandom), 1, 0, 8'h00, 0);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 6)) @(negedge CLK);
        Ks = 8'($urandom);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
      end
      wait_idle();
    end
    check("scoreboard_drained", sb.size(), 0);

    // wide instance: all-ones word with pattern 11, then random words
    for (int t = 0; t < 6; t++) begin
      logic [31:0] f;
      int c;
      int n;
      logic [15:0] ks2v;
      logic k0v;
      ks2v = (t == 0) ? 16'hFFFF : 16'($urandom);
      k0v = (t == 0) ? 1'b0 : 1'($urandom);
      model({16'b0, ks2v}, W2, 2, 32'b11, k0v, f, c);
      @(negedge CLK);
      Ks2 = ks2v;
      K0_2 = k0v;
      START2 = 1'b1;
      @(negedge CLK);
      START2 = 1'b0;
      Ks2 = 16'($urandom);
      n = 0;
      while (!DONE2 && n < 40) begin
        n++;
        @(negedge CLK);
      end
      if (n >= 40) check("done2_timeout", n, 0);
      check("done2_latency", n, W2);
      if (t == 0) begin
        check("w16_flags", FLAGS2, 16'hFFFE);
        check("w16_cnt", CNT2, 15);
`ifdef SEG_HEX_EN
        check("w16_num", NUM2, 8'b10001110);
`else
        check("w16_num", NUM2, 8'b00000000);
`endif
      end else begin
        check("w16_rand_flags", FLAGS2, f[15:0]);
        check("w16_rand_cnt", CNT2, c);
        check("w16_rand_num", NUM2, seg_ref(c));
      end
      @(negedge CLK);
      @(negedge CLK);
      check("w16_busy_after", BUSY2, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
